// File: rtl/pir_alarm_ctrl.sv
// Multi-zone PIR motion alarm: per-channel sync + qualifier, arm/alert/hold FSM, zone latch, pulsed buzzer.
// Optional zone masking (MASK input) is compiled in when PIR_ALARM_ZONE_MASK_EN is defined.
module pir_alarm_ctrl #(
  parameter int N_CH     = 4,
  parameter int QUAL_CYC = 4,
  parameter int HOLD_CYC = 16,
  parameter int TONE_DIV = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ARM,
  input  logic            ACK,
  input  logic [N_CH-1:0] PIR_IN,
`ifdef PIR_ALARM_ZONE_MASK_EN
  input  logic [N_CH-1:0] MASK,
`endif
  output logic            BUZZER,
  output logic            ALARM,
  output logic [N_CH-1:0] ZONE,
  output logic [1:0]      STATE
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_ALERT    = 2'b10,
    ST_HOLD     = 2'b11
  } state_e;

  localparam logic [7:0]  QUAL_V    = 8'(QUAL_CYC);
  localparam logic [7:0]  TONE_LAST = 8'(TONE_DIV - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [7:0]      cnt_q [N_CH];
  logic [7:0]      cnt_d [N_CH];
  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] qual_en;
  logic            any_qual;

  state_e          state_q, state_d;
  logic [N_CH-1:0] zone_q, zone_d;
  logic            buzzer_q, buzzer_d;
  logic [7:0]      tone_q, tone_d;
  logic [15:0]     hold_q, hold_d;
  logic [7:0]      tone_adv;
  logic            buzz_adv;

  // Synchroniser and saturating run-length qualifier per channel
  always_comb begin
    sync1_d = PIR_IN;
    sync2_d = sync1_q;
    qual    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!sync2_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == QUAL_V) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
      qual[i] = (cnt_q[i] == QUAL_V);
    end
  end

`ifdef PIR_ALARM_ZONE_MASK_EN
  assign qual_en = qual & ~MASK;
`else
  assign qual_en = qual;
`endif

  assign any_qual = |qual_en;

  // Tone advance shared by ALERT and HOLD so HOLD<->ALERT never restarts it
  always_comb begin
    if (tone_q == TONE_LAST) begin
      tone_adv = 8'd0;
      buzz_adv = ~buzzer_q;
    end else begin
      tone_adv = tone_q + 8'd1;
      buzz_adv = buzzer_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    zone_d   = zone_q;
    buzzer_d = buzzer_q;
    tone_d   = tone_q;
    hold_d   = hold_q;
    if (!ARM) begin
      state_d  = ST_DISARMED;
      zone_d   = '0;
      buzzer_d = 1'b0;
      tone_d   = 8'd0;
      hold_d   = 16'd0;
    end else if (ACK && (state_q == ST_ALERT || state_q == ST_HOLD)) begin
      state_d  = ST_ARMED;
      zone_d   = '0;
      buzzer_d = 1'b0;
      tone_d   = 8'd0;
      hold_d   = 16'd0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_d  = ST_ARMED;
          buzzer_d = 1'b0;
          tone_d   = 8'd0;
        end
        ST_ARMED: begin
          zone_d   = zone_q | qual_en;
          buzzer_d = 1'b0;
          tone_d   = 8'd0;
          if (any_qual) begin
            state_d  = ST_ALERT;
            buzzer_d = 1'b1;
          end
        end
        ST_ALERT: begin
          zone_d   = zone_q | qual_en;
          tone_d   = tone_adv;
          buzzer_d = buzz_adv;
          if (!any_qual) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          zone_d = zone_q | qual_en;
          if (any_qual) begin
            state_d  = ST_ALERT;
            tone_d   = tone_adv;
            buzzer_d = buzz_adv;
          end else if (hold_q == 16'd0) begin
            state_d  = ST_ARMED;
            buzzer_d = 1'b0;
            tone_d   = 8'd0;
          end else begin
            hold_d   = hold_q - 16'd1;
            tone_d   = tone_adv;
            buzzer_d = buzz_adv;
          end
        end
        default: begin
          state_d  = ST_DISARMED;
          zone_d   = '0;
          buzzer_d = 1'b0;
          tone_d   = 8'd0;
          hold_d   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= 8'd0;
      state_q  <= ST_DISARMED;
      zone_q   <= '0;
      buzzer_q <= 1'b0;
      tone_q   <= 8'd0;
      hold_q   <= 16'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      zone_q   <= zone_d;
      buzzer_q <= buzzer_d;
      tone_q   <= tone_d;
      hold_q   <= hold_d;
    end
  end

  assign STATE  = state_q;
  assign ALARM  = state_q[1];
  assign ZONE   = zone_q;
  assign BUZZER = buzzer_q;

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// Self-checking bench for pir_alarm_ctrl: directed scenarios plus randomized run against a window-based model.
module tb_pir_alarm_ctrl;
  localparam int N_CH     = 4;
  localparam int QUAL_CYC = 4;
  localparam int HOLD_CYC = 16;
  localparam int TONE_DIV = 4;
  localparam int W        = N_CH + 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ARM;
  logic            ACK;
  logic [N_CH-1:0] PIR_IN;
`ifdef PIR_ALARM_ZONE_MASK_EN
  logic [N_CH-1:0] MASK;
`endif
  logic            BUZZER;
  logic            ALARM;
  logic [N_CH-1:0] ZONE;
  logic [1:0]      STATE;

  int errors = 0;
  int checks = 0;

  pir_alarm_ctrl #(
    .N_CH(N_CH), .QUAL_CYC(QUAL_CYC), .HOLD_CYC(HOLD_CYC), .TONE_DIV(TONE_DIV)
  ) dut (
    .CLK(CLK), .RST(RST), .ARM(ARM), .ACK(ACK), .PIR_IN(PIR_IN),
`ifdef PIR_ALARM_ZONE_MASK_EN
    .MASK(MASK),
`endif
    .BUZZER(BUZZER), .ALARM(ALARM), .ZONE(ZONE), .STATE(STATE)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: qualification as "the sensor was high for the last QUAL_CYC
  // samples, seen through a two-sample delay"; tone derived from elapsed alert time.
  logic [N_CH-1:0] hist [QUAL_CYC+2];
  logic [1:0]      m_state = 2'b00;
  logic [N_CH-1:0] m_zone = '0;
  int              m_tone_t = 0;
  int              m_hold_left = 0;
  logic            m_buzz = 1'b0;
  logic            sb_en = 1'b0;
  logic [W-1:0]    exp_q[$];

  always @(posedge CLK or posedge RST) begin
    logic [N_CH-1:0] q;
    logic            anyq;
    if (RST) begin
      for (int j = 0; j < QUAL_CYC + 2; j++) hist[j] = '0;
      m_state = 2'b00;
      m_zone = '0;
      m_tone_t = 0;
      m_hold_left = 0;
    end else begin
      q = '0;
      for (int c = 0; c < N_CH; c++) begin
        q[c] = 1'b1;
        for (int j = 2; j <= QUAL_CYC + 1; j++) if (hist[j][c] !== 1'b1) q[c] = 1'b0;
      end
`ifdef PIR_ALARM_ZONE_MASK_EN
      q = q & ~MASK;
`endif
      anyq = |q;
      if (!ARM) begin
        m_state = 2'b00;
        m_zone = '0;
      end else if (ACK && (m_state == 2'b10 || m_state == 2'b11)) begin
        m_state = 2'b01;
        m_zone = '0;
      end else begin
        case (m_state)
          2'b00: m_state = 2'b01;
          2'b01: begin
            m_zone = m_zone | q;
            if (anyq) begin
              m_state = 2'b10;
              m_tone_t = 0;
            end
          end
          2'b10: begin
            m_zone = m_zone | q;
            m_tone_t++;
            if (!anyq) begin
              m_state = 2'b11;
              m_hold_left = HOLD_CYC;
            end
          end
          default: begin
            m_zone = m_zone | q;
            m_tone_t++;
            if (anyq) m_state = 2'b10;
            else begin
              m_hold_left--;
              if (m_hold_left == 0) m_state = 2'b01;
            end
          end
        endcase
      end
      for (int j = QUAL_CYC + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = PIR_IN;
    end
    m_buzz = (m_state == 2'b10 || m_state == 2'b11) ? (((m_tone_t / TONE_DIV) % 2) == 0) : 1'b0;
    if (sb_en && CLK) exp_q.push_back({m_state, (m_state == 2'b10 || m_state == 2'b11), m_buzz, m_zone});
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; ARM = 1'b1; ACK = 1'b0; PIR_IN = 4'hF;
`ifdef PIR_ALARM_ZONE_MASK_EN
    MASK = '0;
`endif
    cyc(3);
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", STATE); end
    checks++; if (BUZZER !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b exp=0", BUZZER); end
    checks++; if (ZONE !== 4'b0000) begin errors++; $display("FAIL reset_zone got=%b exp=0000", ZONE); end
    checks++; if (ALARM !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", ALARM); end
    PIR_IN = 4'h0; RST = 1'b0;
    cyc(1);
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL reset_release_armed got=%b exp=01", STATE); end
  endtask

  task automatic test_qualification();
    int alert_k;
    PIR_IN = 4'b0100; cyc(3);
    PIR_IN = 4'b0000; cyc(10);
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL glitch_state got=%b exp=01", STATE); end
    checks++; if (ZONE !== 4'b0000) begin errors++; $display("FAIL glitch_zone got=%b exp=0000", ZONE); end
    alert_k = -1;
    for (int k = 0; k <= 12; k++) begin
      PIR_IN = (k < 10) ? 4'b0100 : 4'b0000;
      cyc(1);
      if (alert_k < 0 && STATE == 2'b10) alert_k = k;
      checks++; if (STATE !== m_state) begin errors++; $display("FAIL qual_state_k%0d got=%b exp=%b", k, STATE, m_state); end
      if (k >= QUAL_CYC + 2) begin
        checks++;
        if (BUZZER !== ((((k - (QUAL_CYC + 2)) / TONE_DIV) % 2) == 0))
          begin errors++; $display("FAIL qual_tone_k%0d got=%b", k, BUZZER); end
      end
    end
    checks++; if (alert_k != QUAL_CYC + 2) begin errors++; $display("FAIL qual_latency got=%0d exp=%0d", alert_k, QUAL_CYC + 2); end
    checks++; if (ZONE !== 4'b0100) begin errors++; $display("FAIL qual_zone got=%b exp=0100", ZONE); end
  endtask

  task automatic test_hold();
    int  hold_cnt;
    bit  done;
    bit  found;
    hold_cnt = 0; done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      cyc(1);
      if (n == 0) begin
        checks++; if (STATE !== 2'b11) begin errors++; $display("FAIL hold_entry got=%b exp=11", STATE); end
      end
      if (STATE == 2'b11) hold_cnt++;
      else if (STATE == 2'b01) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL hold_timeout got=%b exp=01", STATE); end
    checks++; if (hold_cnt != HOLD_CYC) begin errors++; $display("FAIL hold_length got=%0d exp=%0d", hold_cnt, HOLD_CYC); end
    checks++; if (BUZZER !== 1'b0) begin errors++; $display("FAIL hold_exit_buzzer got=%b exp=0", BUZZER); end
    checks++; if (ZONE !== 4'b0100) begin errors++; $display("FAIL hold_exit_zone got=%b exp=0100", ZONE); end
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      PIR_IN = (i < 8) ? 4'b0100 : 4'b0000;
      cyc(1);
      if (i >= 8 && STATE == 2'b11) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL hold_reentry got=%b exp=11", STATE); end
    for (int i = 0; i < 10; i++) begin
      PIR_IN = 4'b0001;
      cyc(1);
      checks++;
      if ({STATE, BUZZER, ZONE} !== {m_state, m_buzz, m_zone})
        begin errors++; $display("FAIL retrigger_i%0d got=%b exp=%b", i, {STATE, BUZZER, ZONE}, {m_state, m_buzz, m_zone}); end
    end
    checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL retrigger_state got=%b exp=10", STATE); end
    checks++; if (ZONE !== 4'b0101) begin errors++; $display("FAIL retrigger_zone got=%b exp=0101", ZONE); end
  endtask

  task automatic test_ack_collision();
    bit found;
    found = 0;
    PIR_IN = 4'b0000;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (STATE == 2'b11) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ack_wait_hold got=%b exp=11", STATE); end
    PIR_IN = 4'b0010;
    cyc(QUAL_CYC + 2);
    ACK = 1'b1;
    cyc(1);
    ACK = 1'b0;
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL ack_state got=%b exp=01", STATE); end
    checks++; if (ZONE !== 4'b0000) begin errors++; $display("FAIL ack_zone got=%b exp=0000", ZONE); end
    checks++; if (BUZZER !== 1'b0) begin errors++; $display("FAIL ack_buzzer got=%b exp=0", BUZZER); end
    cyc(1);
    checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL ack_realert got=%b exp=10", STATE); end
    checks++; if (ZONE !== 4'b0010) begin errors++; $display("FAIL ack_realert_zone got=%b exp=0010", ZONE); end
    checks++; if (BUZZER !== 1'b1) begin errors++; $display("FAIL ack_realert_buzzer got=%b exp=1", BUZZER); end
  endtask

  task automatic test_disarm();
    ARM = 1'b0;
    cyc(1);
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL disarm_state got=%b exp=00", STATE); end
    checks++; if (BUZZER !== 1'b0) begin errors++; $display("FAIL disarm_buzzer got=%b exp=0", BUZZER); end
    checks++; if (ALARM !== 1'b0) begin errors++; $display("FAIL disarm_alarm got=%b exp=0", ALARM); end
    checks++; if (ZONE !== 4'b0000) begin errors++; $display("FAIL disarm_zone got=%b exp=0000", ZONE); end
    PIR_IN = 4'hF;
    cyc(10);
    checks++; if ({STATE, ZONE, BUZZER} !== 7'b0) begin errors++; $display("FAIL disarm_motion got=%b exp=0000000", {STATE, ZONE, BUZZER}); end
    PIR_IN = 4'h0;
    cyc(QUAL_CYC + 4);
    ARM = 1'b1;
    cyc(4);
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL rearm_state got=%b exp=01", STATE); end
  endtask

`ifdef PIR_ALARM_ZONE_MASK_EN
  task automatic test_mask();
    MASK = 4'b0001; PIR_IN = 4'b0001;
    cyc(12);
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL mask_state got=%b exp=01", STATE); end
    checks++; if (ZONE !== 4'b0000) begin errors++; $display("FAIL mask_zone got=%b exp=0000", ZONE); end
    PIR_IN = 4'b1001;
    cyc(QUAL_CYC + 3);
    checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL mask_alert got=%b exp=10", STATE); end
    checks++; if (ZONE !== 4'b1000) begin errors++; $display("FAIL mask_alert_zone got=%b exp=1000", ZONE); end
    PIR_IN = 4'b0000; MASK = 4'b0000;
    cyc(QUAL_CYC + 4);
    ACK = 1'b1; cyc(1); ACK = 1'b0;
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL mask_ack got=%b exp=01", STATE); end
  endtask
`endif

  task automatic test_async_reset();
    bit found;
    found = 0;
    PIR_IN = 4'b0100;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (STATE == 2'b10) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL areset_wait_alert got=%b exp=10", STATE); end
    #2 RST = 1'b1;
    #1;
    checks++; if ({STATE, ALARM, BUZZER, ZONE} !== 8'b0)
      begin errors++; $display("FAIL areset_outputs got=%b exp=00000000", {STATE, ALARM, BUZZER, ZONE}); end
    @(negedge CLK);
    RST = 1'b0; PIR_IN = 4'b0000;
    cyc(1);
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL areset_release got=%b exp=01", STATE); end
  endtask

  // scoreboard-driven randomized run
  task automatic test_random();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    exp_q.delete();
    sb_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) ARM = ~ARM;
      ACK = ($urandom_range(0, 39) == 0);
      RST = ($urandom_range(0, 699) == 0);
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 9) == 0) PIR_IN[c] = ~PIR_IN[c];
`ifdef PIR_ALARM_ZONE_MASK_EN
      if ($urandom_range(0, 99) == 0) MASK = 4'($urandom_range(0, 15));
`endif
      cyc(1);
      got = {STATE, ALARM, BUZZER, ZONE};
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL random_n%0d empty expected queue got=%b", n, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin errors++; $display("FAIL random_n%0d got=%b exp=%b", n, got, exp); end
      end
    end
    sb_en = 1'b0;
    RST = 1'b0; ACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_qualification();
    test_hold();
    test_ack_collision();
    test_disarm();
`ifdef PIR_ALARM_ZONE_MASK_EN
    test_mask();
`endif
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pir_alarm_ctrl.md
# pir_alarm_ctrl

Multi-zone motion alarm controller, parametrised successor to the single-channel PIR buzzer driver. Synchronises and qualifies N_CH PIR inputs, runs an arm/alert/hold state machine, latches which zones tripped, and drives a pulsed buzzer tone until motion ends and a hold period expires, or until acknowledged. Sits between the PIR sensor pins and the buzzer/indicator outputs.

## Interface
- N_CH, 4: number of PIR channels (1..16).
- QUAL_CYC, 4: consecutive synchronised-high samples required to qualify motion (1..255).
- HOLD_CYC, 16: cycles the alarm persists after the last qualified motion (1..65535).
- TONE_DIV, 4: buzzer half-period in cycles (1..255).

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ARM  in  1  level; 1 = system armed, 0 = disarmed.
- ACK  in  1  single-cycle acknowledge; silences the current alert and clears the zone latch.
- PIR_IN  in  N_CH  raw asynchronous sensor inputs, 1 = motion.
- BUZZER  out  1  pulsed tone output.
- ALARM  out  1  1 while STATE is ALERT or HOLD.
- ZONE  out  N_CH  sticky latch of zones that qualified since last ACK/disarm.
- STATE  out  2  FSM state encoding.

## Operation
- Per channel: 2-flop synchroniser, then saturating counter cnt[i] (0..QUAL_CYC). Synchronised 1 -> cnt increments (saturates at QUAL_CYC); synchronised 0 -> cnt = 0. qual[i] = (cnt[i] == QUAL_CYC). any_q = OR of qual.
- States: DISARMED=2'b00, ARMED=2'b01, ALERT=2'b10, HOLD=2'b11.
- Priority in every state: ARM=0 -> DISARMED, ZONE cleared, BUZZER 0. Next: ACK (in ALERT/HOLD) -> ARMED, ZONE cleared.
- DISARMED: ARM=1 -> ARMED. Qualifiers keep running; ZONE not updated.
- ARMED: any_q -> ALERT.
- ALERT: any_q=0 -> HOLD, hold counter loaded with HOLD_CYC-1.
- HOLD: any_q -> ALERT; else hold counter = 0 -> ARMED; else decrement.
- ZONE: in ARMED/ALERT/HOLD, ZONE <= ZONE | qual each cycle (unless cleared by ACK/disarm that cycle, clear wins). ZONE persists after automatic HOLD->ARMED return.
- BUZZER: registered. On the edge entering ALERT from ARMED, BUZZER <= 1 and tone counter <= 0; in ALERT/HOLD tone counter increments, at TONE_DIV-1 it wraps to 0 and BUZZER toggles. HOLD<->ALERT transitions do not restart the tone. Any other state: BUZZER 0, tone counter 0.
- ALARM, STATE derived directly from state register (no extra delay).

## Timing
- Reset values: STATE=DISARMED, BUZZER=0, ALARM=0, ZONE=0, all cnt, synchronisers, hold and tone counters 0.
- Detection latency (armed): PIR_IN first sampled high at edge 0 -> STATE=ALERT, BUZZER=1 after edge QUAL_CYC+2 (6 edges with defaults), provided PIR_IN stays high.
- Glitch shorter than QUAL_CYC synchronised cycles: no alert, no ZONE bit.
- Motion end: last synchronised-high cycle -> HOLD one edge after the 0 reaches cnt; HOLD lasts exactly HOLD_CYC cycles then ARMED.
- BUZZER period 2*TONE_DIV cycles, 50% duty.
- ACK and new any_q in the same cycle: ACK wins (-> ARMED, ZONE cleared); re-alert on the next edge if qual still true.
- ARM deassert mid-alert: DISARMED on next edge, BUZZER 0 same edge.
- RST asserted at any time: all outputs to reset values immediately, independent of CLK.

## Configuration
- PIR_ALARM_ZONE_MASK_EN defined: extra input MASK [N_CH]; qual[i] is gated by ~MASK[i] before any_q and ZONE (counters still run). Masking a zone mid-alert removes it from any_q on the next cycle; its ZONE bit stays set.
- Not defined: no MASK port; all channels always enabled.

## Test plan
- Reset: RST=1 with PIR_IN=4'hF, ARM=1 -> STATE=00, BUZZER=0, ZONE=0; release RST -> ARMED next edge.
- Qualification: ARM=1, PIR_IN[2] high 3 cycles then low -> no ALERT; high 10 cycles -> ALERT 6 edges after first sample, ZONE=4'b0100, BUZZER toggles every 4 cycles.
- Hold: after above, PIR_IN=0 -> HOLD, 16 cycles later ARMED, BUZZER=0, ZONE still 4'b0100; retrigger PIR_IN[0] during HOLD -> ALERT, ZONE=4'b0101, no tone restart.
- ACK/collision: ACK pulse coincident with PIR_IN[1] qualifying -> ARMED, ZONE=0, then ALERT next edge with ZONE=4'b0010.
- Disarm: ARM=0 during ALERT -> DISARMED next edge, BUZZER=0, ALARM=0, ZONE=0; motion while disarmed -> no change.
- Mask (macro on): MASK=4'b0001, PIR_IN[0] held high -> stays ARMED, ZONE=0; PIR_IN[3] high -> ALERT, ZONE=4'b1000.
